// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: shares one external multiplier between two requesters.
//
// A round-robin arbiter picks a requester in IDLE and acknowledges it in the
// same cycle it is sampled. Its operands are latched onto mul_a/mul_b, and
// mul_start is pulsed once. The controller then waits for mul_done and
// returns the product on res together with a vld pulse to the granted side.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req0/req1               multiply requests, held high until ack
//   a0/b0, a1/b1            32-bit operands of each requester
//   ack0/ack1               operands latched (pulse, only while IDLE)
//   vld0/vld1               res/err valid for that requester (pulse)
//   res, err                product / timeout flag, held until next response
//   busy                    high in every state except IDLE
//   mul_start, mul_a/mul_b  start pulse and operands to the multiplier
//   mul_done, mul_p         completion pulse and product from the multiplier
//
// Optional build macro MUL_SHARE_TIMEOUT_EN:
//   - When defined, WAIT is abandoned after TIMEOUT idle cycles. The
//     response then returns res=0 and err=1.
//   - When not defined, err is tied low and no counter exists.
//
// state | meaning
// IDLE  | no grant outstanding; arbitrate and acknowledge a request
// ISSUE | pulse mul_start with the latched operands
// WAIT  | wait for mul_done (or timeout, if enabled)
// RESP  | pulse vld of the granted requester

`timescale 1ns/1ps

module mul_share_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        ack0,
    output logic        ack1,
    output logic        vld0,
    output logic        vld1,
    output logic [63:0] res,
    output logic        err,
    output logic        busy,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_done,
    input  logic [63:0] mul_p
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state, state_nxt;
    logic   last;       // requester served most recently
    logic   gnt;        // requester owning the current operation
    logic   pick;       // arbitration winner this cycle
    logic   take;       // a grant happens at the coming edge

`ifdef MUL_SHARE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;
    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT));
`endif

    // With both requests pending, the side not served last wins.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1)
            pick = ~last;
        else
            pick = req1;
        take = (state == IDLE) && (req0 || req1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (req0 || req1) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (mul_done)
                    state_nxt = RESP;
`ifdef MUL_SHARE_TIMEOUT_EN
                else if (tmo_hit)
                    state_nxt = RESP;
`endif
            end
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ack is a Mealy output of IDLE. It is gated by rst_n so that a request
    // held across reset is not acknowledged while reset is active.
    always_comb begin
        ack0      = 1'b0;
        ack1      = 1'b0;
        vld0      = 1'b0;
        vld1      = 1'b0;
        mul_start = 1'b0;
        busy      = (state != IDLE);
        if (take && rst_n) begin
            ack0 = ~pick;
            ack1 = pick;
        end
        if (state == ISSUE)
            mul_start = 1'b1;
        if (state == RESP) begin
            vld0 = ~gnt;
            vld1 = gnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last    <= 1'b1;
            gnt     <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
            res     <= '0;
`ifdef MUL_SHARE_TIMEOUT_EN
            err     <= 1'b0;
            tmo_cnt <= '0;
`endif
        end else begin
            if (take) begin
                gnt   <= pick;
                last  <= pick;
                mul_a <= pick ? a1 : a0;
                mul_b <= pick ? b1 : b0;
            end
`ifdef MUL_SHARE_TIMEOUT_EN
            if (state == ISSUE)
                tmo_cnt <= '0;
            if (state == WAIT) begin
                if (mul_done) begin
                    res <= mul_p;
                    err <= 1'b0;
                end else if (tmo_hit) begin
                    res <= '0;
                    err <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
`else
            if (state == WAIT && mul_done)
                res <= mul_p;
`endif
        end
    end

`ifndef MUL_SHARE_TIMEOUT_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_share_ctrl.sv
`timescale 1ns/1ps

module tb_mul_share_ctrl;

    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        ack0, ack1, vld0, vld1, err, busy, mul_start;
    logic [63:0] res;
    logic [31:0] mul_a, mul_b;
    logic        mul_done = 1'b0;
    logic [63:0] mul_p = '0;

    mul_share_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .vld0(vld0), .vld1(vld1),
        .res(res), .err(err), .busy(busy),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_p(mul_p)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_start = 0, n_ack = 0, n_vld = 0, n_ack_busy = 0;

    always @(negedge clk) begin
        if (mul_start) n_start++;
        if (ack0 || ack1) n_ack++;
        if (vld0 || vld1) n_vld++;
        if ((ack0 || ack1) && busy) n_ack_busy++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ack0"}, ack0, 0);
        chk({tag, "_ack1"}, ack1, 0);
        chk({tag, "_vld0"}, vld0, 0);
        chk({tag, "_vld1"}, vld1, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_start"}, mul_start, 0);
        chk({tag, "_mul_a"}, mul_a, 0);
        chk({tag, "_mul_b"}, mul_b, 0);
        chk({tag, "_res"}, res, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Called in IDLE right after driving requests; checks the ack and ISSUE.
    task automatic grant(input bit who, input logic [31:0] ea, input logic [31:0] eb,
                         input bit drop);
        #1;
        chk("ack0", ack0, (who == 1'b0));
        chk("ack1", ack1, (who == 1'b1));
        chk("busy_idle", busy, 0);
        tick;
        if (drop) begin
            if (who) req1 = 1'b0;
            else     req0 = 1'b0;
        end
        chk("issue_start", mul_start, 1);
        chk("issue_busy", busy, 1);
        chk("issue_ack", ack0 | ack1, 0);
        chk("issue_mul_a", mul_a, ea);
        chk("issue_mul_b", mul_b, eb);
    endtask

    // From ISSUE: pulse mul_done lat cycles after mul_start, check response.
    task automatic finish(input bit who, input int lat, input logic [63:0] p);
        tick;
        chk("wait_start", mul_start, 0);
        repeat (lat - 1) tick;
        mul_done = 1'b1;
        mul_p    = p;
        tick;
        mul_done = 1'b0;
        mul_p    = '0;
        chk("resp_vld0", vld0, (who == 1'b0));
        chk("resp_vld1", vld1, (who == 1'b1));
        chk("resp_res", res, p);
        chk("resp_err", err, 0);
        tick;
        chk("post_vld", vld0 | vld1, 0);
        chk("post_busy", busy, 0);
        chk("post_res", res, p);
    endtask

    logic [31:0] rr_a [3] = '{32'd10, 32'd11, 32'd12};
    logic [31:0] rr_b [3] = '{32'd20, 32'd21, 32'd22};
    logic [63:0] rr_p [3] = '{64'd200, 64'd231, 64'd264};
    int nv;

    initial begin
        // Reset values
        repeat (2) tick;
        chk_quiet("rst");
        rst_n = 1'b1;
        tick;

        // Single request 3*5 with a 34-cycle multiplier
        req0 = 1'b1; a0 = 32'd3; b0 = 32'd5;
        grant(1'b0, 32'd3, 32'd5, 1'b1);
        finish(1'b0, 34, 64'd15);
        chk("single_n_start", n_start, 1);
        chk("single_n_ack", n_ack, 1);
        chk("single_n_vld", n_vld, 1);

        // Tie right after reset: 0 first, then 1, then 0 again
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        req0 = 1'b1; req1 = 1'b1;
        a0 = 32'd3; b0 = 32'd5; a1 = 32'hFFFF_FFFF; b1 = 32'd2;
        grant(1'b0, 32'd3, 32'd5, 1'b1);
        finish(1'b0, 2, 64'd15);
        req0 = 1'b1; a0 = 32'd7; b0 = 32'd9;
        grant(1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1);
        finish(1'b1, 3, 64'h1_FFFF_FFFE);
        grant(1'b0, 32'd7, 32'd9, 1'b1);
        finish(1'b0, 1, 64'd63);

        // req1 held continuously; operands may change after ack
        req1 = 1'b1;
        a1 = rr_a[0]; b1 = rr_b[0];
        for (int i = 0; i < 3; i++) begin
            grant(1'b1, rr_a[i], rr_b[i], 1'b0);
            if (i < 2) begin
                a1 = rr_a[i+1]; b1 = rr_b[i+1];
            end else begin
                a1 = 32'hDEAD_BEEF; b1 = 32'hDEAD_BEEF;
            end
            #1;
            chk("hold_mul_a", mul_a, rr_a[i]);
            chk("hold_mul_b", mul_b, rr_b[i]);
            finish(1'b1, 2, rr_p[i]);
        end
        req1 = 1'b0;
        chk("ack_while_busy", n_ack_busy, 0);

        // Reset during WAIT, late mul_done ignored
        req0 = 1'b1; a0 = 32'd6; b0 = 32'd7;
        grant(1'b0, 32'd6, 32'd7, 1'b1);
        repeat (3) tick;
        chk("wait_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_quiet("midrst");
        tick;
        rst_n = 1'b1;
        nv = n_vld;
        mul_done = 1'b1; mul_p = 64'd99;
        tick;
        mul_done = 1'b0; mul_p = '0;
        chk("late_done_busy", busy, 0);
        chk("late_done_vld", vld0 | vld1, 0);
        chk("late_done_res", res, 0);
        tick;
        chk("late_done_nvld", n_vld, nv);
        chk("idle_done_busy", busy, 0);

        req0 = 1'b1;
        grant(1'b0, 32'd6, 32'd7, 1'b1);
        finish(1'b0, 5, 64'd42);

        // Multiplier never answers
        req0 = 1'b1; a0 = 32'd2; b0 = 32'd2;
        grant(1'b0, 32'd2, 32'd2, 1'b1);
        tick;
`ifdef MUL_SHARE_TIMEOUT_EN
        repeat (TIMEOUT) tick;
        chk("tmo_before_vld", vld0, 0);
        chk("tmo_before_busy", busy, 1);
        tick;
        chk("tmo_vld0", vld0, 1);
        chk("tmo_err", err, 1);
        chk("tmo_res", res, 0);
        tick;
        chk("tmo_idle", busy, 0);
`else
        repeat (60) tick;
        chk("stuck_busy", busy, 1);
        chk("stuck_vld", vld0 | vld1, 0);
        chk("stuck_err", err, 0);
        rst_n = 1'b0;
        #1;
        chk("stuck_rst_busy", busy, 0);
        tick;
        rst_n = 1'b1;
        tick;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
